// File: rtl/ad_avg_filter.sv
// ad_avg_filter: N-sample moving-average filter for a 24-bit two's-complement ADC
// stream, where N = 2**AVG_LOG2. The first result appears only after the window
// has been filled with N samples.
//   clk_sys  - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   flt_en   - enable; low flushes the window and holds the block idle
//   ad_data  - ADC sample, qualified by ad_vld (single-cycle strobe)
//   flt_data - averaged sample, qualified by flt_vld; the value is held until
//              flt_rdy accepts it
//   flt_ovf  - sticky: a result that had not been accepted was overwritten
//   drop_cnt - saturating count of overwritten results and ignored strobes
module ad_avg_filter #(
  parameter int unsigned AVG_LOG2 = 3
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        flt_en,
  input  logic [23:0] ad_data,
  input  logic        ad_vld,
  output logic [23:0] flt_data,
  output logic        flt_vld,
  input  logic        flt_rdy,
  output logic        flt_ovf,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned DW = 24;
  localparam int unsigned N  = 1 << AVG_LOG2;
  localparam int unsigned SW = DW + AVG_LOG2;
  localparam int unsigned PW = AVG_LOG2;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] s1_data_q;
  logic          s1_vld_q;
  logic          s2_vld_q;
  logic          res_pend_q;
  logic [DW-1:0] win_q [N];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] fill_cnt_q;
  logic [SW-1:0] sum_q, sum_d;
  logic [DW-1:0] flt_data_q;
  logic          flt_vld_q;
  logic          flt_ovf_q;
  logic [7:0]    drop_cnt_q;

  logic clear, active, busy, take, skip, last_fill, produce, ovw, drop;

  // Qualifiers for strobes, results and drop events
  always_comb begin
    clear     = !flt_en || (state_q == ST_IDLE);
    active    = flt_en && (state_q != ST_IDLE);
    busy      = s1_vld_q || s2_vld_q;
    take      = active && ad_vld && !busy;
    skip      = active && ad_vld && busy;
    last_fill = (state_q == ST_FILL) && (fill_cnt_q == PW'(N - 1));
    produce   = s1_vld_q && ((state_q == ST_RUN) || last_fill);
    ovw       = res_pend_q && flt_vld_q && !flt_rdy;
    drop      = skip || ovw;
    // Oldest entry leaves the window as the new sample enters it
    sum_d     = sum_q + {{AVG_LOG2{s1_data_q[DW-1]}}, s1_data_q}
                      - {{AVG_LOG2{win_q[wr_ptr_q][DW-1]}}, win_q[wr_ptr_q]};
  end

  // FSM state register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; disabling wins over any other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (flt_en) state_d = ST_FILL;
      ST_FILL: if (s1_vld_q && last_fill) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    if (!flt_en) state_d = ST_IDLE;
  end

  // Datapath: capture -> window/sum update -> result register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n || clear) begin
      s1_data_q  <= '0;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      res_pend_q <= 1'b0;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      sum_q      <= '0;
      flt_data_q <= '0;
      flt_vld_q  <= 1'b0;
      flt_ovf_q  <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < int'(N); i++) win_q[i] <= '0;
    end else begin
      s1_vld_q   <= take;
      s2_vld_q   <= s1_vld_q;
      res_pend_q <= produce;
      if (take) s1_data_q <= ad_data;
      if (s1_vld_q) begin
        win_q[wr_ptr_q] <= s1_data_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);  // N is a power of two: wraps N-1 -> 0
        sum_q           <= sum_d;
        if (state_q == ST_FILL) fill_cnt_q <= fill_cnt_q + PW'(1);
      end
      // A load on the same edge as an accept keeps flt_vld high with the new data
      if (res_pend_q) begin
        flt_data_q <= sum_q[SW-1:AVG_LOG2];
        flt_vld_q  <= 1'b1;
      end else if (flt_rdy) begin
        flt_vld_q  <= 1'b0;
      end
      if (ovw) flt_ovf_q <= 1'b1;
      // Coincident drop events count once
      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign flt_data = flt_data_q;
  assign flt_vld  = flt_vld_q;
  assign flt_ovf  = flt_ovf_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_ad_avg_filter.sv
// Directed bench for ad_avg_filter: a 4-tap instance and a 16-tap instance share
// the same stimulus, and each phase checks only the instance it targets.
module tb_ad_avg_filter;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        flt_en;
  logic [23:0] ad_data;
  logic        ad_vld;
  logic        flt_rdy;

  logic [23:0] d2_data, d4_data;
  logic        d2_vld, d4_vld, d2_ovf, d4_ovf;
  logic [7:0]  d2_drop, d4_drop;

  int n_pass  = 0;
  int n_total = 0;

  logic [23:0] exp_neg [4] = '{24'h00003F, 24'hFFFFFF, 24'h00003F, 24'hFFFFFF};

  always #5 clk_sys = ~clk_sys;

  ad_avg_filter #(.AVG_LOG2(2)) u_avg4 (
    .clk_sys(clk_sys), .rst_n(rst_n), .flt_en(flt_en), .ad_data(ad_data),
    .ad_vld(ad_vld), .flt_data(d2_data), .flt_vld(d2_vld), .flt_rdy(flt_rdy),
    .flt_ovf(d2_ovf), .drop_cnt(d2_drop)
  );

  ad_avg_filter #(.AVG_LOG2(4)) u_avg16 (
    .clk_sys(clk_sys), .rst_n(rst_n), .flt_en(flt_en), .ad_data(ad_data),
    .ad_vld(ad_vld), .flt_data(d4_data), .flt_vld(d4_vld), .flt_rdy(flt_rdy),
    .flt_ovf(d4_ovf), .drop_cnt(d4_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk_sys);
  endtask

  // One-cycle strobe; returns at the negedge after the capture edge
  task automatic strobe(input logic [23:0] d);
    @(negedge clk_sys);
    ad_vld  = 1'b1;
    ad_data = d;
    @(negedge clk_sys);
    ad_vld  = 1'b0;
  endtask

  // Strobe, then advance to the cycle in which its result is first visible
  task automatic strobe_res(input logic [23:0] d);
    strobe(d);
    cyc(2);
  endtask

  // Drop enable long enough to return to IDLE, then re-enable
  task automatic flush();
    @(negedge clk_sys);
    flt_en = 1'b0;
    cyc(2);
    flt_en = 1'b1;
    cyc(1);
  endtask

  initial begin
    rst_n = 1'b0; flt_en = 1'b0; ad_data = '0; ad_vld = 1'b0; flt_rdy = 1'b1;
    cyc(2);
    check("rst_data", 32'(d2_data), 32'h0);
    check("rst_vld",  32'(d2_vld),  32'h0);
    check("rst_ovf",  32'(d2_ovf),  32'h0);
    check("rst_drop", 32'(d2_drop), 32'h0);
    check("rst_vld16", 32'(d4_vld), 32'h0);
    @(negedge clk_sys);
    rst_n = 1'b1; flt_en = 1'b1;
    cyc(2);

    // Four equal samples: silent during fill, one-cycle result on the fourth
    for (int i = 0; i < 3; i++) begin
      strobe(24'h000100);
      cyc(1);
      check("fill_t2", 32'(d2_vld), 32'h0);
      cyc(1);
      check("fill_t3", 32'(d2_vld), 32'h0);
      cyc(96);
    end
    strobe(24'h000100);
    cyc(1);
    check("first_t2_vld", 32'(d2_vld), 32'h0);
    cyc(1);
    check("first_t3_vld",  32'(d2_vld),  32'h1);
    check("first_t3_data", 32'(d2_data), 32'h000100);
    cyc(1);
    check("first_t4_vld", 32'(d2_vld), 32'h0);
    cyc(5);

    // Strobes while disabled are neither used nor counted
    @(negedge clk_sys);
    flt_en = 1'b0;
    cyc(1);
    strobe(24'h123456);
    cyc(3);
    check("dis_drop", 32'(d2_drop), 32'h0);
    check("dis_vld",  32'(d2_vld),  32'h0);
    flt_en = 1'b1;
    cyc(1);

    // Alternating +/-256 averages to zero; then floor behaviour on negatives
    for (int i = 0; i < 8; i++) begin
      strobe_res((i % 2 == 0) ? 24'hFFFF00 : 24'h000100);
      if (i >= 3) begin
        check("alt_vld",  32'(d2_vld),  32'h1);
        check("alt_data", 32'(d2_data), 32'h0);
      end else begin
        check("alt_fill_vld", 32'(d2_vld), 32'h0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      strobe_res(24'hFFFFFF);
      check("neg_data", 32'(d2_data), 32'(exp_neg[i]));
    end

    // 16-tap full-scale extremes
    flush();
    for (int i = 0; i < 16; i++) begin
      strobe_res(24'h7FFFFF);
      if (i == 15) begin
        check("max_vld",  32'(d4_vld),  32'h1);
        check("max_data", 32'(d4_data), 32'h7FFFFF);
      end else begin
        check("max_fill_vld", 32'(d4_vld), 32'h0);
      end
    end
    for (int i = 0; i < 16; i++) begin
      strobe_res(24'h800000);
      if (i == 7)  check("mid_data", 32'(d4_data), 32'hFFFFFF);
      if (i == 15) check("min_data", 32'(d4_data), 32'h800000);
    end

    // Unaccepted result overwritten by the next one
    flush();
    for (int i = 0; i < 4; i++) strobe_res(24'h000010);
    check("ovf_base", 32'(d2_data), 32'h000010);
    cyc(2);
    flt_rdy = 1'b0;
    strobe_res(24'h000050);
    check("hold_data", 32'(d2_data), 32'h000020);
    check("hold_ovf",  32'(d2_ovf),  32'h0);
    check("hold_drop", 32'(d2_drop), 32'h0);
    cyc(2);
    check("hold_vld", 32'(d2_vld), 32'h1);
    strobe_res(24'h000090);
    check("ovw_data", 32'(d2_data), 32'h000040);
    check("ovw_vld",  32'(d2_vld),  32'h1);
    check("ovw_ovf",  32'(d2_ovf),  32'h1);
    check("ovw_drop", 32'(d2_drop), 32'h1);
    flt_rdy = 1'b1;
    cyc(2);
    check("ovw_drain_vld",  32'(d2_vld), 32'h0);
    check("ovw_sticky_ovf", 32'(d2_ovf), 32'h1);

    // Accept on the same edge as the new load: no overflow
    flush();
    check("flush_ovf",  32'(d2_ovf),  32'h0);
    check("flush_drop", 32'(d2_drop), 32'h0);
    for (int i = 0; i < 4; i++) strobe_res(24'h000010);
    cyc(2);
    flt_rdy = 1'b0;
    strobe_res(24'h000050);
    strobe(24'h000090);
    cyc(1);
    flt_rdy = 1'b1;
    cyc(1);
    check("same_edge_vld",  32'(d2_vld),  32'h1);
    check("same_edge_data", 32'(d2_data), 32'h000040);
    check("same_edge_ovf",  32'(d2_ovf),  32'h0);
    check("same_edge_drop", 32'(d2_drop), 32'h0);
    cyc(1);
    check("same_edge_fall", 32'(d2_vld), 32'h0);

    // Strobes two cycles apart: second ignored, counter saturates
    flush();
    strobe(24'h000001);
    strobe(24'h000001);
    cyc(1);
    check("close_drop1", 32'(d2_drop), 32'h1);
    for (int i = 0; i < 9; i++) begin
      strobe(24'h000001);
      strobe(24'h000001);
    end
    cyc(1);
    check("close_drop10", 32'(d2_drop), 32'd10);
    for (int i = 0; i < 290; i++) begin
      strobe(24'h000001);
      strobe(24'h000001);
    end
    cyc(1);
    check("close_drop_sat", 32'(d2_drop), 32'd255);

    // Enable drop mid-fill discards partial window
    flush();
    check("refill_drop_clr", 32'(d2_drop), 32'h0);
    strobe_res(24'h001000);
    strobe_res(24'h001000);
    cyc(2);
    flush();
    for (int i = 0; i < 4; i++) begin
      strobe_res(24'h000040);
      if (i == 3) begin
        check("en_refill_vld",  32'(d2_vld),  32'h1);
        check("en_refill_data", 32'(d2_data), 32'h000040);
      end else begin
        check("en_refill_quiet", 32'(d2_vld), 32'h0);
      end
    end

    // Reset pulse mid-fill discards partial window
    flush();
    strobe_res(24'h001000);
    strobe_res(24'h001000);
    cyc(2);
    @(negedge clk_sys);
    rst_n = 1'b0;
    cyc(1);
    check("rst_mid_vld", 32'(d2_vld), 32'h0);
    rst_n = 1'b1;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      strobe_res(24'h000040);
      if (i == 3) begin
        check("rst_refill_vld",  32'(d2_vld),  32'h1);
        check("rst_refill_data", 32'(d2_data), 32'h000040);
      end else begin
        check("rst_refill_quiet", 32'(d2_vld), 32'h0);
      end
    end

    cyc(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
